sram_bus_arb: RTL
=================

SRAM_BUS_ARB -- requirements
Module: sram_bus_arb

Interface
REQ-001 Parameter WAIT, default 1, meaning extra DATA-phase cycles per access (0..3).
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 m0_req  input  1  CPU port request, held high until m0_ack.
REQ-005 m0_we  input  1  CPU port write (1) / read (0).
REQ-006 m0_addr  input  7  CPU port nibble address.
REQ-007 m0_wdata  input  4  CPU port write data.
REQ-008 m0_ack  output  1  one-cycle completion pulse.
REQ-009 m0_rdata  output  4  read data, valid while m0_ack is high.
REQ-010 m1_req, m1_we, m1_addr[6:0], m1_wdata[3:0], m1_ack, m1_rdata[3:0]: loader port, same meaning as m0_*.
REQ-011 bus_out  output  8  multiplexed SRAM bus: [7] address strobe, [6:0] address in ADDR phase; otherwise [5] write enable (active-low), [4] data strobe (active-low), [3:0] write data.
REQ-012 bus_in  input  4  SRAM read data.

Function
REQ-013 FSM states IDLE, ADDR, DATA, ACK; bus_out, acks and rdata SHALL be registered.
REQ-014 IDLE: bus_out = 0x30; on any req sampled high, select winner, capture its addr/we/wdata, next state ADDR.
REQ-015 ADDR (1 cycle): bus_out = {1, addr}; next DATA, load wait counter with WAIT.
REQ-016 DATA (WAIT+1 cycles): bus_out = {0, 0, ~we, 0, we ? wdata : 0}; write -> 0x0D-style {0,0,0,0,wdata}, read -> 0x20.
REQ-017 On the final DATA cycle edge, bus_in SHALL be captured into the winner's rdata register; next ACK.
REQ-018 ACK (1 cycle): bus_out = 0x30, winner's ack = 1, other ack = 0; next IDLE.
REQ-019 Latency: req high at edge k in IDLE -> ack high in cycle k+3+WAIT; one access per 4+WAIT cycles max.
REQ-020 Requester SHALL drop req on the edge that samples ack; req still high in IDLE after ACK is a new request.
REQ-021 req dropped mid-access SHALL NOT abort; access completes and ack still pulses.
REQ-022 Inputs of the non-granted port are ignored until it wins; rdata of a port holds its last value except on its own capture.
REQ-023 Address 0x7F and wdata 0xF SHALL pass unmodified; no address wrap or arithmetic.

Reset
REQ-024 rst low SHALL immediately force state IDLE, bus_out = 0x30, m0_ack = m1_ack = 0, m0_rdata = m1_rdata = 0, last-grant pointer = m1, wait counter = 0.
REQ-025 Reset mid-access SHALL abandon it with no ack; no write strobe after rst asserts.

Configuration
REQ-026 Macro SRAM_ARB_RR_EN defined: round-robin; on simultaneous req the port not granted last wins; pointer updates on each grant.
REQ-027 SRAM_ARB_RR_EN undefined: fixed priority, m0 always wins simultaneous req; pointer logic absent.

Verification (WAIT=1)
REQ-028 m0 write addr 0x5E data 0xA -> bus_out 0xDE, 0x0A, 0x0A, 0x30; m0_ack pulse 4 cycles after req; m1_ack stays 0.
REQ-029 m1 read addr 0x10, bus_in = 0x7 -> bus_out 0x90, 0x20, 0x20, 0x30; m1_ack with m1_rdata = 0x7.
REQ-030 m0 and m1 req together, m0 re-requests after ack -> with SRAM_ARB_RR_EN grants m0, m1, m0; without it grants m0, m0, then m1.
REQ-031 rst low during second DATA cycle of a write -> bus_out 0x30 same cycle, no ack; after release, idle until next req.
REQ-032 No requests for 20 cycles -> bus_out constant 0x30, both acks 0.
REQ-033 WAIT=0 and WAIT=3 builds: m0 read -> DATA lasts 1 and 4 cycles, ack at k+3 and k+6.

Source files
------------

// File: rtl/sram_bus_arb.sv
// sram_bus_arb
// Two-master arbiter in front of a nibble-wide SRAM reached through an
// 8-bit multiplexed bus. m0 is the CPU port and m1 is the loader port.
// Each access runs IDLE -> ADDR -> DATA (WAIT+1 cycles) -> ACK -> IDLE.
//
// Build option: define SRAM_ARB_RR_EN for round-robin arbitration. When
// both ports request at once, the port that did not win last time wins.
// Without it, arbitration is fixed priority and m0 always wins a tie.
//
// Handshake: a master raises mX_req with we/addr/wdata stable and holds
// it until it samples mX_ack. mX_ack is a one-cycle pulse and mX_rdata is
// valid during that pulse. Dropping req mid-access does not abort the
// access. A req still high in IDLE after the ACK cycle is a new request.
//
// Ports
//   clk            single clock, rising edge
//   rst            asynchronous reset, active low
//   m0_req/we      CPU request / write(1) read(0)
//   m0_addr[6:0]   CPU nibble address
//   m0_wdata[3:0]  CPU write data
//   m0_ack         CPU completion pulse
//   m0_rdata[3:0]  CPU read data (holds until the next m0 capture)
//   m1_*           loader port, same meaning as m0_*
//   bus_out[7:0]   ADDR phase: {1, addr}
//                  other phases: {0, 0, we_n, ds_n, wdata}
//   bus_in[3:0]    SRAM read data
//   dbg_state[1:0] current FSM state (0 IDLE, 1 ADDR, 2 DATA, 3 ACK)
module sram_bus_arb #(
  parameter int WAIT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       m0_req,
  input  logic       m0_we,
  input  logic [6:0] m0_addr,
  input  logic [3:0] m0_wdata,
  output logic       m0_ack,
  output logic [3:0] m0_rdata,
  input  logic       m1_req,
  input  logic       m1_we,
  input  logic [6:0] m1_addr,
  input  logic [3:0] m1_wdata,
  output logic       m1_ack,
  output logic [3:0] m1_rdata,
  output logic [7:0] bus_out,
  input  logic [3:0] bus_in,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_ACK  = 2'd3
  } state_t;

  localparam logic [1:0] WAIT_CNT = 2'(WAIT);
  localparam logic [7:0] BUS_IDLE = 8'h30;

  state_t     r_state;
  logic       r_gnt;     // 0: m0 owns the current access, 1: m1
  logic       r_we;
  logic [6:0] r_addr;
  logic [3:0] r_wdata;
  logic [1:0] r_cnt;
  logic [7:0] r_bus;
  logic       r_ack0;
  logic       r_ack1;
  logic [3:0] r_rd0;
  logic [3:0] r_rd1;

  state_t     w_state_nxt;
  logic       w_gnt_nxt;
  logic       w_we_nxt;
  logic [6:0] w_addr_nxt;
  logic [3:0] w_wdata_nxt;
  logic [1:0] w_cnt_nxt;
  logic       w_rd_cap;
  logic [7:0] w_bus_nxt;
  logic       w_ack0_nxt;
  logic       w_ack1_nxt;
  logic       w_pick;    // port that wins if a grant happens this cycle

`ifdef SRAM_ARB_RR_EN
  logic r_last;          // port granted most recently

  // On a tie the port not granted last wins.
  assign w_pick = (m0_req & m1_req) ? ~r_last : ~m0_req;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last <= 1'b1;
    end else if (r_state == S_IDLE && (m0_req | m1_req)) begin
      r_last <= w_pick;
    end
  end
`else
  // Fixed priority: m1 is picked only when m0 is not asking.
  assign w_pick = ~m0_req;
`endif

  // Next-state and next-output logic. Outputs are computed from the
  // next state so that bus_out, acks and rdata leave registers aligned
  // with the state they belong to.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_we_nxt    = r_we;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_cnt_nxt   = r_cnt;
    w_rd_cap    = 1'b0;
    w_bus_nxt   = BUS_IDLE;
    w_ack0_nxt  = 1'b0;
    w_ack1_nxt  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (m0_req | m1_req) begin
          w_state_nxt = S_ADDR;
          w_gnt_nxt   = w_pick;
          w_we_nxt    = w_pick ? m1_we    : m0_we;
          w_addr_nxt  = w_pick ? m1_addr  : m0_addr;
          w_wdata_nxt = w_pick ? m1_wdata : m0_wdata;
        end
      end
      S_ADDR: begin
        w_state_nxt = S_DATA;
        w_cnt_nxt   = WAIT_CNT;
      end
      S_DATA: begin
        if (r_cnt == 2'd0) begin
          w_state_nxt = S_ACK;
          w_rd_cap    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 2'd1;
        end
      end
      S_ACK: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    case (w_state_nxt)
      S_ADDR: w_bus_nxt = {1'b1, w_addr_nxt};
      // Data strobe low for the whole DATA phase; write enable low only
      // for writes. Reads keep the data nibble at zero.
      S_DATA: w_bus_nxt = {2'b00, ~w_we_nxt, 1'b0,
                           (w_we_nxt ? w_wdata_nxt : 4'h0)};
      S_ACK: begin
        w_ack0_nxt = ~w_gnt_nxt;
        w_ack1_nxt = w_gnt_nxt;
      end
      default: w_bus_nxt = BUS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_gnt   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= 7'h00;
      r_wdata <= 4'h0;
      r_cnt   <= 2'd0;
      r_bus   <= BUS_IDLE;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_rd0   <= 4'h0;
      r_rd1   <= 4'h0;
    end else begin
      r_gnt   <= w_gnt_nxt;
      r_we    <= w_we_nxt;
      r_addr  <= w_addr_nxt;
      r_wdata <= w_wdata_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bus   <= w_bus_nxt;
      r_ack0  <= w_ack0_nxt;
      r_ack1  <= w_ack1_nxt;
      // Only the owner's rdata moves; the other port keeps its value.
      if (w_rd_cap) begin
        if (r_gnt) begin
          r_rd1 <= bus_in;
        end else begin
          r_rd0 <= bus_in;
        end
      end
    end
  end

  assign bus_out   = r_bus;
  assign m0_ack    = r_ack0;
  assign m1_ack    = r_ack1;
  assign m0_rdata  = r_rd0;
  assign m1_rdata  = r_rd1;
  assign dbg_state = r_state;

endmodule
